// File: rtl/fft_frame_streamer.sv
// Frame engine for an AXI-Stream FFT core. It sends one config beat, streams one
// buffered input frame and captures the result frame, flagging framing errors and capture timeouts.
module fft_frame_streamer #(
   parameter int DATA_W    = 32,
   parameter int FRAME_LEN = 16,
   parameter int CFG_W     = 8,
   parameter int TIMEOUT   = 4096
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic                         ld_en,
   input  logic [$clog2(FRAME_LEN)-1:0] ld_addr,
   input  logic [DATA_W-1:0]            ld_data,
   input  logic                         start,
   input  logic                         fwd_inv,
   output logic                         busy,
   output logic                         done,
   output logic                         err_last,
   output logic                         err_timeout,
   output logic [CFG_W-1:0]             cfg_data,
   output logic                         cfg_valid,
   input  logic                         cfg_ready,
   output logic [DATA_W-1:0]            m_data,
   output logic                         m_valid,
   output logic                         m_last,
   input  logic                         m_ready,
   input  logic [DATA_W-1:0]            s_data,
   input  logic                         s_valid,
   input  logic                         s_last,
   output logic                         s_ready,
   input  logic [$clog2(FRAME_LEN)-1:0] rd_addr,
   output logic [DATA_W-1:0]            rd_data
);
   localparam int AW = $clog2(FRAME_LEN);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   LAST_IDX = (AW+1)'(FRAME_LEN - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_STREAM, S_CAPTURE, S_DONE} state_t;

   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_in_buf  [FRAME_LEN];
   logic [DATA_W-1:0] r_res_buf [FRAME_LEN];
   logic [AW:0]       r_idx, r_ocnt;
   logic [TW-1:0]     r_tmo;
   logic              r_fwd_inv, r_err_last, r_err_timeout, r_cap_end;
   logic [DATA_W-1:0] r_rd_data;
   logic              w_in_stream, w_s_rdy, w_m_hs, w_at_last;
   logic              w_s_acc, w_beat_end, w_beat_bad, w_tmo_hit;

   assign w_in_stream = (r_state == S_STREAM);
   assign w_s_rdy     = w_in_stream || (r_state == S_CAPTURE);
   assign w_at_last   = (r_idx == LAST_IDX);
   assign w_m_hs      = w_in_stream && m_ready;
   // Once the result frame has ended early (during STREAM), further beats are dropped.
   assign w_s_acc     = s_valid && w_s_rdy && !r_cap_end;
   assign w_beat_end  = w_s_acc && (s_last || (r_ocnt == LAST_IDX));
   assign w_beat_bad  = w_s_acc && (s_last != (r_ocnt == LAST_IDX));
   assign w_tmo_hit   = (r_state == S_CAPTURE) && !w_s_acc && (r_tmo == TMO_LAST);

   assign m_valid     = w_in_stream;
   assign m_last      = w_in_stream && w_at_last;
   assign s_ready     = w_s_rdy;
   assign err_last    = r_err_last;
   assign err_timeout = r_err_timeout;
   assign rd_data     = r_rd_data;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      w_next   = r_state;
      busy     = 1'b1;
      done     = 1'b0;
      cfg_data = '0;
      cfg_valid = 1'b0;
      m_data   = '0;
      unique case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_next = S_CONFIG;
         end
         S_CONFIG: begin
            cfg_data  = CFG_W'(r_fwd_inv);
            cfg_valid = 1'b1;
            if (cfg_ready) w_next = S_STREAM;
         end
         S_STREAM: begin
            m_data = r_in_buf[r_idx[AW-1:0]];
            if (m_ready && w_at_last) w_next = (r_cap_end || w_beat_end) ? S_DONE : S_CAPTURE;
         end
         S_CAPTURE: begin
            if (w_beat_end || w_tmo_hit) w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (areset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_fwd_inv     <= 1'b0;
         r_err_last    <= 1'b0;
         r_err_timeout <= 1'b0;
         r_cap_end     <= 1'b0;
         r_idx         <= '0;
         r_ocnt        <= '0;
         r_tmo         <= '0;
         r_rd_data     <= '0;
      end else begin
         r_rd_data <= r_res_buf[rd_addr];
         if ((r_state == S_IDLE) && start) begin
            r_fwd_inv     <= fwd_inv;
            r_err_last    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_cap_end     <= 1'b0;
            r_idx         <= '0;
            r_ocnt        <= '0;
         end
         if (w_m_hs) r_idx <= r_idx + (AW+1)'(1);
         if (w_s_acc) begin
            r_ocnt <= r_ocnt + (AW+1)'(1);
            if (w_beat_end) r_cap_end  <= 1'b1;
            if (w_beat_bad) r_err_last <= 1'b1;
         end
         if (w_tmo_hit) r_err_timeout <= 1'b1;
         r_tmo <= ((r_state == S_CAPTURE) && !w_s_acc) ? r_tmo + TW'(1) : '0;
      end
   end

   always_ff @(posedge aclk) begin
      // NOTE: buffer storage carries no reset; contents survive areset and are rewritten before use.
      if (!areset && ld_en && (r_state == S_IDLE)) r_in_buf[ld_addr] <= ld_data;
      if (!areset && w_s_acc) r_res_buf[r_ocnt[AW-1:0]] <= s_data;
   end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Randomised self-checking bench for fft_frame_streamer: a behavioural model of the
// frame sequence predicts beats, result contents, error flags and done timing.
module tb_fft_frame_streamer;
   localparam int DW  = 32;
   localparam int FL  = 16;
   localparam int CW  = 8;
   localparam int TMO = 64;
   localparam int AW  = 4;

   logic          aclk = 1'b0, areset = 1'b1;
   logic          ld_en = 1'b0, start = 1'b0, fwd_inv = 1'b0;
   logic [AW-1:0] ld_addr = '0, rd_addr = '0;
   logic [DW-1:0] ld_data = '0, s_data = '0;
   logic          cfg_ready = 1'b0, m_ready = 1'b0, s_valid = 1'b0, s_last = 1'b0;
   logic          busy, done, err_last, err_timeout, cfg_valid, m_valid, m_last, s_ready;
   logic [CW-1:0] cfg_data;
   logic [DW-1:0] m_data, rd_data;

   int            n_checks = 0, n_errors = 0;
   logic [DW-1:0] in_model  [FL];
   logic [DW-1:0] res_model [FL];

   fft_frame_streamer #(.DATA_W(DW), .FRAME_LEN(FL), .CFG_W(CW), .TIMEOUT(TMO)) dut (
      .aclk(aclk), .areset(areset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .start(start), .fwd_inv(fwd_inv), .busy(busy), .done(done), .err_last(err_last),
      .err_timeout(err_timeout), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .rd_addr(rd_addr), .rd_data(rd_data));

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic load(input bit rnd);
      for (int i = 0; i < FL; i++) begin
         ld_en   = 1'b1;
         ld_addr = AW'(i);
         ld_data = rnd ? DW'($urandom) : DW'(i * 32'h200);
         in_model[i] = ld_data;
         @(posedge aclk); #1;
      end
      ld_en = 1'b0;
   endtask

   // One frame: n_res result beats offered after the stream, s_last on beat last_at (-1 none),
   // optional areset once rst_beat input beats have been accepted.
   task automatic run_frame(input bit fwd, input bit rnd_m, input bit noise, input int n_res,
                            input int last_at, input int rst_beat);
      int cfg_seen = 0, cfg_hs = 0, m_cnt = 0, s_cnt = 0, done_cnt = 0;
      int done_cyc = -1, exp_done = -1, last_evt = -1, end_beat = -1, rst_cyc = -1;
      bit stall = 1'b0, ended = 1'b0, finished = 1'b0, exp_err_last, exp_err_tmo;
      logic [DW-1:0] hold_data = '0;
      logic          hold_last = 1'b0;
      for (int k = 0; k < n_res; k++)
         if (end_beat < 0 && (k == last_at || k == FL - 1)) end_beat = k;
      exp_err_last = (end_beat >= 0) && !(end_beat == FL - 1 && last_at == FL - 1);
      exp_err_tmo  = (end_beat < 0);
      start   = 1'b1;
      fwd_inv = fwd;
      for (int c = 0; c < 3000; c++) begin
         @(negedge aclk);
         if (rst_cyc >= 0) begin
            if (done) done_cnt++;
            if (c == rst_cyc + 1) begin
               check("rst_m_valid", m_valid, 0);
               check("rst_busy", busy, 0);
               check("rst_s_ready", s_ready, 0);
            end
            if (c == rst_cyc + 6) begin
               check("rst_no_done", done_cnt, 0);
               finished = 1'b1;
               break;
            end
         end else begin
            if (c == 1) begin
               check("busy_on_start", busy, 1);
               check("err_cleared", {err_last, err_timeout}, 0);
            end
            if (cfg_valid) begin
               cfg_seen++;
               if (cfg_ready) begin
                  cfg_hs++;
                  check("cfg_data", cfg_data, CW'(fwd));
               end
            end
            if (stall) begin
               check("m_hold_data", m_data, hold_data);
               check("m_hold_last", m_last, hold_last);
            end
            if (m_cnt > 0 && m_cnt < FL) check("m_valid_hold", m_valid, 1);
            stall     = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
            if (m_valid && m_ready) begin
               check("m_data", m_data, in_model[(m_cnt < FL) ? m_cnt : FL - 1]);
               check("m_last", m_last, m_cnt == FL - 1);
               m_cnt++;
               if (m_cnt == FL) last_evt = c;
            end
            if (s_valid && s_ready) begin
               if (s_cnt < FL) res_model[s_cnt] = s_data;
               if (s_cnt == end_beat) begin
                  exp_done = c + 1;
                  ended    = 1'b1;
               end
               s_cnt++;
               last_evt = c;
            end
            if (done) begin
               done_cnt++;
               if (done_cyc < 0) begin
                  done_cyc = c;
                  check("done_busy", busy, 1);
                  check("done_s_ready", s_ready, 0);
               end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) check("busy_after_done", busy, 0);
            if (done_cyc >= 0 && c == done_cyc + 3) begin
               finished = 1'b1;
               break;
            end
         end
         @(posedge aclk); #1;
         start     = 1'b0;
         cfg_ready = (cfg_seen >= 2);
         m_ready   = rnd_m ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rst_cyc >= 0) begin
            areset  = 1'b0;
            ld_en   = 1'b0;
            s_valid = 1'b0;
         end else begin
            if (rst_beat >= 0 && m_cnt == rst_beat) begin
               areset  = 1'b1;
               rst_cyc = c + 1;
            end
            if (m_cnt == FL && !ended && s_cnt < n_res) begin
               s_valid = 1'b1;
               s_data  = DW'($urandom);
               s_last  = (s_cnt == last_at);
            end else begin
               s_valid = 1'b0;
               s_last  = 1'b0;
            end
            if (noise && done_cnt == 0 && rst_cyc < 0) begin
               ld_en   = 1'($urandom_range(0, 1));
               ld_addr = AW'($urandom);
               ld_data = DW'($urandom);
            end else begin
               ld_en = 1'b0;
            end
         end
      end
      @(posedge aclk); #1;
      start = 1'b0; cfg_ready = 1'b0; m_ready = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      ld_en = 1'b0; areset = 1'b0;
      check("frame_finished", finished, 1);
      if (rst_beat < 0) begin
         if (exp_err_tmo) exp_done = last_evt + TMO + 1;
         check("cfg_handshakes", cfg_hs, 1);
         check("m_beats", m_cnt, FL);
         check("s_beats", s_cnt, end_beat + 1);
         check("done_pulses", done_cnt, 1);
         check("done_cycle", done_cyc, exp_done);
         check("err_last", err_last, exp_err_last);
         check("err_timeout", err_timeout, exp_err_tmo);
         for (int i = 0; i < s_cnt && i < FL; i++) begin
            rd_addr = AW'(i);
            @(posedge aclk); #1;
            check("rd_data", rd_data, res_model[i]);
         end
      end
   endtask

   initial begin
      areset = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check("rst_outputs", {busy, done, err_last, err_timeout, cfg_valid, m_valid, m_last, s_ready}, 0);
      check("rst_cfg_data", cfg_data, 0);
      check("rst_m_data", m_data, 0);
      check("rst_rd_data", rd_data, 0);
      areset = 1'b0;
      @(posedge aclk); #1;

      load(1'b0);
      run_frame(1'b1, 1'b0, 1'b0, 16, 15, -1);   // baseline frame
      load(1'b1);
      run_frame(1'b0, 1'b1, 1'b1, 16, 15, -1);   // stalls, load attempts while busy
      run_frame(1'b1, 1'b1, 1'b0, 16, 9, -1);    // early s_last
      run_frame(1'b1, 1'b0, 1'b0, 16, -1, -1);   // missing s_last
      run_frame(1'b0, 1'b0, 1'b0, 0, -1, -1);    // no results: timeout
      run_frame(1'b1, 1'b0, 1'b0, 16, 15, -1);   // flags cleared again
      run_frame(1'b1, 1'b0, 1'b0, 16, 15, 5);    // reset mid-stream
      run_frame(1'b0, 1'b1, 1'b0, 16, 15, -1);   // fresh frame after reset

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fft_frame_streamer.md
Name: fft_frame_streamer

Overview:
- Synthesizable frame engine that drives an AXI-Stream FFT core.
- Holds one frame of input samples in a local buffer. On start it issues one config beat, streams the frame with last on the final beat, then captures the transform result into a local result buffer.
- Generalises the fixed 16-point, fixed-width bench flow to a parametrised frame length and sample width, and adds framing-error and timeout detection.
- Sits between the control/register layer and fft_top.

Parameters:
- DATA_W, 32, sample width (re/im packed) on all data paths.
- FRAME_LEN, 16, points per frame; power of 2, 4..1024.
- CFG_W, 8, width of the FFT config word.
- TIMEOUT, 4096, max idle cycles in CAPTURE before abort; must be ≥ 1.

Ports:
- aclk, in, 1, clock; all logic on rising edge.
- areset, in, 1, synchronous active-high reset.
- ld_en, in, 1, write one sample into the input buffer.
- ld_addr, in, log2(FRAME_LEN), input buffer address.
- ld_data, in, DATA_W, sample to write.
- start, in, 1, single-cycle pulse that begins a frame.
- fwd_inv, in, 1, transform direction: 1 = forward, 0 = inverse.
- busy, out, 1, high from the accepted start until done.
- done, out, 1, one-cycle pulse when the frame completes or aborts.
- err_last, out, 1, sticky framing error for the last completed frame.
- err_timeout, out, 1, sticky capture-timeout error for the last completed frame.
- cfg_data, out, CFG_W, config word to the FFT core.
- cfg_valid, out, 1, config valid.
- cfg_ready, in, 1, config ready.
- m_data, out, DATA_W, sample to the FFT core.
- m_valid, out, 1, sample valid.
- m_last, out, 1, final sample of the frame.
- m_ready, in, 1, FFT core ready.
- s_data, in, DATA_W, FFT result beat.
- s_valid, in, 1, result valid.
- s_last, in, 1, result last.
- s_ready, out, 1, streamer ready to accept results.
- rd_addr, in, log2(FRAME_LEN), result buffer read address.
- rd_data, out, DATA_W, result word; registered, 1-cycle latency.

Behaviour:
- Reset state:
  - State is IDLE.
  - busy, done, err_last, err_timeout, cfg_valid, m_valid, m_last and s_ready are 0.
  - cfg_data, m_data and rd_data are 0.
  - Buffer contents are not cleared.
- Reset mid-operation: areset forces IDLE on the same edge. All valids/readies read 0 in the following cycle. No partial-frame done pulse is generated.
- IDLE:
  - ld_en writes ld_data into input buffer[ld_addr].
  - start=1 latches fwd_inv, clears both error flags, sets busy and moves to CONFIG.
  - ld_en while busy is ignored; the input buffer is frozen for the whole frame.
  - start while busy is ignored.
- CONFIG:
  - cfg_data = {(CFG_W-1)'b0, latched fwd_inv}; cfg_valid=1.
  - cfg_valid is held until the edge where cfg_valid & cfg_ready, then the FSM moves to STREAM.
- STREAM:
  - m_valid=1; m_data = input buffer[idx], with idx starting at 0.
  - m_last = (idx == FRAME_LEN-1).
  - idx advances only on m_valid & m_ready. m_data and m_last stay stable while m_ready=0.
  - m_valid is never dropped mid-frame.
  - After the handshake with m_last=1, the FSM moves to CAPTURE and m_valid and m_last fall next cycle.
- s_ready is 1 in STREAM and CAPTURE and 0 otherwise, so early result beats are accepted.
- Capture rule:
  - Each s_valid & s_ready beat writes s_data into result buffer[ocnt], then ocnt increments.
  - This applies in STREAM as well as CAPTURE.
- Capture end conditions:
  - Beat with s_last=1 and ocnt==FRAME_LEN-1: normal end.
  - Beat with s_last=1 and ocnt<FRAME_LEN-1: set err_last; end the frame.
  - Beat at ocnt==FRAME_LEN-1 with s_last=0: set err_last; end the frame.
- CAPTURE timeout:
  - A cycle counter resets on every accepted beat.
  - Reaching TIMEOUT idle cycles sets err_timeout and ends the frame.
- Frame end:
  - FSM moves to DONE for one cycle: done=1, busy=0 on the following cycle, s_ready=0, then returns to IDLE.
  - A new start is accepted from IDLE only, so there is at least one idle cycle between frames.
- Result read:
  - rd_data <= result buffer[rd_addr] every cycle, in any state.
  - A read of a slot being written in the same cycle returns the old value.
- Widths: idx and ocnt are log2(FRAME_LEN)+1 bits, so there is no wrap-around within a frame. No arithmetic is applied to sample data.

Test Plan:
- Load 16 samples 0x00000000, 0x00000200, … then start with fwd_inv=1, cfg_ready=1 after 2 cycles, and m_ready/s_ready always high. Expect cfg_data=0x01 for exactly one handshake, 16 m beats in address order with m_last only on beat 15, 16 results stored at rd_addr 0..15, done a single pulse, and both error flags 0.
- Toggle m_ready randomly (~50%). Expect m_data/m_last held stable across stalls, exactly 16 handshakes, and no beat duplicated or skipped.
- Assert s_last on result beat 9 (FRAME_LEN=16). Expect err_last=1, done on the next cycle, and rd_addr 0..9 holding the captured beats.
- Send 16 result beats without s_last. Expect err_last=1 and done after beat 15.
- Send no results, with TIMEOUT=64. Expect err_timeout=1 and done 64 cycles after entering CAPTURE. A following start clears both flags.
- Pulse areset during STREAM at beat 5. Expect m_valid=0 and busy=0 on the next cycle, no done pulse, and a fresh start that streams from beat 0.
